// File: rtl/mem_access_unit.sv
// Data-memory access stage: alignment check, word-addressed valid/ready bus
// access with byte enables, and load data right-justified for extension.
module mem_access_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_req,
    input  logic        I_we,
    input  logic [2:0]  I_funct3,
    input  logic [31:0] I_addr,
    input  logic [31:0] I_wdata,
    output logic        O_busy,
    output logic        O_done,
    output logic [31:0] O_rdata,
    output logic        O_error,
    output logic [1:0]  O_errcode,
    output logic        O_bus_valid,
    output logic        O_bus_we,
    output logic [31:0] O_bus_addr,
    output logic [3:0]  O_bus_be,
    output logic [31:0] O_bus_wdata,
    input  logic        I_bus_ready,
    input  logic [31:0] I_bus_rdata,
    output logic [1:0]  O_dbg_state
);

    // Bus handshake: a transfer completes in the cycle where O_bus_valid and
    // I_bus_ready are both high; address, enables and data stay stable until then.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    localparam logic [31:0] TIMEOUT_L = 32'(TIMEOUT);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_we;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [1:0]  r_errcode;
    logic [31:0] r_cnt;

    logic        w_illegal;
    logic        w_misaligned;
    logic        w_timeout;
    logic        w_latch;
    logic        w_capture;
    logic [1:0]  w_errcode_next;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    // Decode the incoming request; illegal encodings win over misalignment.
    always_comb begin
        w_illegal    = 1'b0;
        w_misaligned = 1'b0;
        case (I_funct3)
            3'b011, 3'b110, 3'b111: w_illegal = 1'b1;
            3'b100, 3'b101:         w_illegal = I_we;
            default:                w_illegal = 1'b0;
        endcase
        case (I_funct3[1:0])
            2'b01:   w_misaligned = I_addr[0];
            2'b10:   w_misaligned = (I_addr[1:0] != 2'b00);
            default: w_misaligned = 1'b0;
        endcase
    end

    assign w_timeout = (TIMEOUT_L != 32'd0) && ((r_cnt + 32'd1) == TIMEOUT_L);

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_errcode_next = r_errcode;
        w_latch        = 1'b0;
        w_capture      = 1'b0;
        O_busy         = 1'b0;
        O_done         = 1'b0;
        O_error        = 1'b0;
        O_errcode      = ERR_NONE;
        O_bus_valid    = 1'b0;
        O_bus_we       = 1'b0;
        O_bus_addr     = 32'd0;
        O_bus_be       = 4'd0;
        O_bus_wdata    = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (I_req) begin
                    w_latch = 1'b1;
                    if (w_illegal) begin
                        w_state_next   = S_DONE;
                        w_errcode_next = ERR_ILLEGAL;
                    end else if (w_misaligned) begin
                        w_state_next   = S_DONE;
                        w_errcode_next = ERR_MISALIGN;
                    end else begin
                        w_state_next   = S_BUS;
                        w_errcode_next = ERR_NONE;
                    end
                end
            end
            S_BUS: begin
                O_busy      = 1'b1;
                O_bus_valid = 1'b1;
                O_bus_we    = r_we;
                O_bus_addr  = {r_addr[31:2], 2'b00};
                O_bus_be    = w_be;
                O_bus_wdata = w_wdata;
                if (I_bus_ready) begin
                    w_state_next   = S_DONE;
                    w_errcode_next = ERR_NONE;
                    w_capture      = ~r_we;
                end else if (w_timeout) begin
                    w_state_next   = S_DONE;
                    w_errcode_next = ERR_TIMEOUT;
                end
            end
            S_DONE: begin
                O_busy       = 1'b1;
                O_done       = 1'b1;
                O_error      = (r_errcode != ERR_NONE);
                O_errcode    = r_errcode;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Lane steering from the latched size and low address bits.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = r_wdata;
        case (r_size)
            2'b00: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_wdata = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << {r_addr[1], 1'b0};
                w_wdata = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = r_wdata;
            end
        endcase
        if (!r_we) begin
            w_wdata = 32'd0;
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_we      <= 1'b0;
            r_size    <= 2'd0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_rdata   <= 32'd0;
            r_errcode <= ERR_NONE;
            r_cnt     <= 32'd0;
        end else begin
            if (w_latch) begin
                r_we    <= I_we;
                r_size  <= I_funct3[1:0];
                r_addr  <= I_addr;
                r_wdata <= I_wdata;
            end
            r_errcode <= w_errcode_next;
            if (w_capture) begin
                r_rdata <= I_bus_rdata >> {r_addr[1:0], 3'b000};
            end
            // Counts wait cycles; anything other than a stalled BUS cycle clears it.
            if ((r_state == S_BUS) && !I_bus_ready) begin
                r_cnt <= r_cnt + 32'd1;
            end else begin
                r_cnt <= 32'd0;
            end
        end
    end

    assign O_rdata     = r_rdata;
    assign O_dbg_state = r_state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: aligned/misaligned/illegal accesses,
// wait states, timeout, request blocking while busy and mid-access reset.
module tb_mem_access_unit;

    logic        I_clk;
    logic        I_rst;
    logic        I_req;
    logic        I_we;
    logic [2:0]  I_funct3;
    logic [31:0] I_addr;
    logic [31:0] I_wdata;
    logic        O_busy;
    logic        O_done;
    logic [31:0] O_rdata;
    logic        O_error;
    logic [1:0]  O_errcode;
    logic        O_bus_valid;
    logic        O_bus_we;
    logic [31:0] O_bus_addr;
    logic [3:0]  O_bus_be;
    logic [31:0] O_bus_wdata;
    logic        I_bus_ready;
    logic [31:0] I_bus_rdata;
    logic [1:0]  O_dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    mem_access_unit #(.TIMEOUT(4)) dut (
        .I_clk(I_clk), .I_rst(I_rst), .I_req(I_req), .I_we(I_we),
        .I_funct3(I_funct3), .I_addr(I_addr), .I_wdata(I_wdata),
        .O_busy(O_busy), .O_done(O_done), .O_rdata(O_rdata),
        .O_error(O_error), .O_errcode(O_errcode),
        .O_bus_valid(O_bus_valid), .O_bus_we(O_bus_we),
        .O_bus_addr(O_bus_addr), .O_bus_be(O_bus_be),
        .O_bus_wdata(O_bus_wdata), .I_bus_ready(I_bus_ready),
        .I_bus_rdata(I_bus_rdata), .O_dbg_state(O_dbg_state)
    );

    initial begin
        I_clk = 1'b0;
        forever #5 I_clk = ~I_clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issues one request at a negedge, serves the bus with 'waits' stall cycles,
    // then checks the completion cycle and the return to idle.
    task automatic run_access(input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int waits, input logic [31:0] bus_rd,
                              input logic [31:0] exp_addr, input logic [3:0] exp_be,
                              input logic [31:0] exp_wd, input logic [1:0] exp_code,
                              input int exp_vcycles, input logic [31:0] exp_rd);
        int vcnt;
        logic [31:0] exp_val;
        exp_q.push_back(exp_rd);
        I_req = 1'b1; I_we = we; I_funct3 = f3; I_addr = addr; I_wdata = wdata;
        @(negedge I_clk);
        I_req = 1'b0;
        I_addr = ~addr;
        I_wdata = ~wdata;
        vcnt = 0;
        while (O_bus_valid && vcnt < 50) begin
            check_eq("bus_addr", O_bus_addr, exp_addr);
            check_eq("bus_be", {28'd0, O_bus_be}, {28'd0, exp_be});
            check_eq("bus_we", {31'd0, O_bus_we}, {31'd0, we});
            check_eq("bus_wdata", O_bus_wdata, exp_wd);
            check_eq("busy_in_bus", {31'd0, O_busy}, 32'd1);
            I_bus_ready = (vcnt == waits);
            I_bus_rdata = (vcnt == waits) ? bus_rd : 32'hDEAD_BEEF;
            vcnt++;
            @(negedge I_clk);
        end
        I_bus_ready = 1'b0;
        I_bus_rdata = 32'd0;
        check_eq("valid_cycles", vcnt, exp_vcycles);
        check_eq("done", {31'd0, O_done}, 32'd1);
        check_eq("error", {31'd0, O_error}, {31'd0, (exp_code != 2'b00)});
        check_eq("errcode", {30'd0, O_errcode}, {30'd0, exp_code});
        exp_val = exp_q.pop_front();
        check_eq("rdata", O_rdata, exp_val);
        @(negedge I_clk);
        check_eq("done_one_cycle", {31'd0, O_done}, 32'd0);
        check_eq("idle_busy", {31'd0, O_busy}, 32'd0);
        check_eq("idle_errcode", {30'd0, O_errcode}, 32'd0);
        check_eq("idle_bus_addr", O_bus_addr, 32'd0);
    endtask

    initial begin
        I_rst = 1'b1; I_req = 1'b0; I_we = 1'b0; I_funct3 = 3'd0;
        I_addr = 32'd0; I_wdata = 32'd0; I_bus_ready = 1'b0; I_bus_rdata = 32'd0;
        repeat (3) @(negedge I_clk);
        check_eq("rst_busy", {31'd0, O_busy}, 32'd0);
        check_eq("rst_done", {31'd0, O_done}, 32'd0);
        check_eq("rst_rdata", O_rdata, 32'd0);
        check_eq("rst_valid", {31'd0, O_bus_valid}, 32'd0);
        check_eq("rst_bus_wdata", O_bus_wdata, 32'd0);
        check_eq("rst_state", {30'd0, O_dbg_state}, 32'd0);
        I_rst = 1'b0;
        @(negedge I_clk);

        // LBU 0x103, zero-wait
        run_access(1'b0, 3'b100, 32'h103, 32'h0, 0, 32'hAABB_CCDD,
                   32'h100, 4'b1000, 32'h0, 2'b00, 1, 32'h0000_00AA);
        // SH 0x202 with three wait cycles
        run_access(1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 3, 32'h0,
                   32'h200, 4'b1100, 32'hABCD_ABCD, 2'b00, 4, 32'h0000_00AA);
        // SB 0x003 and SW 0x010
        run_access(1'b1, 3'b000, 32'h003, 32'h0000_00EF, 0, 32'h0,
                   32'h000, 4'b1000, 32'hEFEF_EFEF, 2'b00, 1, 32'h0000_00AA);
        run_access(1'b1, 3'b010, 32'h010, 32'hCAFE_F00D, 1, 32'h0,
                   32'h010, 4'b1111, 32'hCAFE_F00D, 2'b00, 2, 32'h0000_00AA);
        // Error cases: no bus cycle, done one cycle after the request
        run_access(1'b0, 3'b010, 32'h301, 32'h0, 0, 32'h0,
                   32'h0, 4'b0, 32'h0, 2'b01, 0, 32'h0000_00AA);
        run_access(1'b0, 3'b001, 32'h003, 32'h0, 0, 32'h0,
                   32'h0, 4'b0, 32'h0, 2'b01, 0, 32'h0000_00AA);
        run_access(1'b0, 3'b011, 32'h000, 32'h0, 0, 32'h0,
                   32'h0, 4'b0, 32'h0, 2'b11, 0, 32'h0000_00AA);
        run_access(1'b1, 3'b100, 32'h000, 32'h0, 0, 32'h0,
                   32'h0, 4'b0, 32'h0, 2'b11, 0, 32'h0000_00AA);
        run_access(1'b1, 3'b101, 32'h001, 32'h0, 0, 32'h0,
                   32'h0, 4'b0, 32'h0, 2'b11, 0, 32'h0000_00AA);
        run_access(1'b0, 3'b110, 32'h000, 32'h0, 0, 32'h0,
                   32'h0, 4'b0, 32'h0, 2'b11, 0, 32'h0000_00AA);
        // Timeout: ready never comes, TIMEOUT=4
        run_access(1'b0, 3'b010, 32'h400, 32'h0, 100, 32'h0,
                   32'h400, 4'b1111, 32'h0, 2'b10, 4, 32'h0000_00AA);

        // Back-to-back: request held high through BUS and DONE
        I_req = 1'b1; I_we = 1'b0; I_funct3 = 3'b000; I_addr = 32'h001;
        @(negedge I_clk);
        check_eq("b2b_valid1", {31'd0, O_bus_valid}, 32'd1);
        check_eq("b2b_be1", {28'd0, O_bus_be}, 32'h2);
        I_bus_ready = 1'b1; I_bus_rdata = 32'h1122_3344;
        I_funct3 = 3'b101; I_addr = 32'h002;
        @(negedge I_clk);
        I_bus_ready = 1'b0;
        check_eq("b2b_done1", {31'd0, O_done}, 32'd1);
        check_eq("b2b_rdata1", O_rdata, 32'h0011_2233);
        @(negedge I_clk);
        check_eq("b2b_ignored_busy", {31'd0, O_busy}, 32'd0);
        check_eq("b2b_ignored_valid", {31'd0, O_bus_valid}, 32'd0);
        @(negedge I_clk);
        check_eq("b2b_valid2", {31'd0, O_bus_valid}, 32'd1);
        check_eq("b2b_be2", {28'd0, O_bus_be}, 32'hC);
        check_eq("b2b_addr2", O_bus_addr, 32'h0);
        I_req = 1'b0; I_bus_ready = 1'b1; I_bus_rdata = 32'h5566_7788;
        @(negedge I_clk);
        I_bus_ready = 1'b0;
        check_eq("b2b_done2", {31'd0, O_done}, 32'd1);
        check_eq("b2b_rdata2", O_rdata, 32'h0000_5566);
        @(negedge I_clk);

        // Reset while in BUS abandons the access
        I_req = 1'b1; I_we = 1'b0; I_funct3 = 3'b010; I_addr = 32'h500;
        @(negedge I_clk);
        I_req = 1'b0;
        check_eq("rstmid_valid_before", {31'd0, O_bus_valid}, 32'd1);
        I_rst = 1'b1;
        @(negedge I_clk);
        I_rst = 1'b0;
        check_eq("rstmid_valid", {31'd0, O_bus_valid}, 32'd0);
        check_eq("rstmid_busy", {31'd0, O_busy}, 32'd0);
        check_eq("rstmid_rdata", O_rdata, 32'd0);
        check_eq("rstmid_done", {31'd0, O_done}, 32'd0);
        @(negedge I_clk);
        check_eq("rstmid_no_done", {31'd0, O_done}, 32'd0);
        run_access(1'b0, 3'b000, 32'h000, 32'h0, 0, 32'h0000_0080,
                   32'h000, 4'b0001, 32'h0, 2'b00, 1, 32'h0000_0080);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
